// File: rtl/reaction_round_sequencer.sv
// rtl/reaction_round_sequencer.sv - multi-round reaction-time game sequencer driving the shared ms timer (optional feature macro: REACTION_FALSE_START_EN)
module reaction_round_sequencer #(
  parameter int MAX_MS    = 2047,
  parameter int ROUNDS    = 5,
  parameter int LED_COUNT = 18,
  localparam int TW = $clog2(MAX_MS),
  localparam int RW = $clog2(ROUNDS + 1),
  localparam int LW = $clog2(LED_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 button_pressed,
  input  logic [TW-1:0]        timer_value,
  input  logic [LW-1:0]        random_value,
  input  logic [TW-1:0]        delay_value,
  output logic                 timer_reset,
  output logic                 timer_load,
  output logic [TW-1:0]        timer_load_value,
  output logic                 timer_up,
  output logic                 timer_enable,
  output logic [LED_COUNT-1:0] led_on,
  output logic [RW-1:0]        round_idx,
  output logic                 result_valid,
  output logic [TW-1:0]        result_time,
  output logic                 timeout,
  output logic                 foul,
  output logic [TW-1:0]        best_time,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_REACT,
    S_RECORD,
    S_FOUL,
    S_DONE
  } state_t;

  localparam logic [TW-1:0] MAX_T = TW'(MAX_MS);
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  state_t        state, state_n;
  logic          start_q, btn_q;
  logic          start_edge, btn_edge;
  logic [LW-1:0] led_idx;
  logic          session_start, latch_led, latch_press, latch_timeout, record;

  assign start_edge = start & ~start_q;
  assign btn_edge   = button_pressed & ~btn_q;

  // Previous-level registers for rising-edge detection on both buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      btn_q   <= 1'b0;
    end else begin
      start_q <= start;
      btn_q   <= button_pressed;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // Next-state and Moore output decode; the WAIT timer_reset follows timer_value directly
  always_comb begin
    state_n          = state;
    timer_reset      = 1'b0;
    timer_load       = 1'b0;
    timer_load_value = '0;
    timer_up         = 1'b0;
    timer_enable     = 1'b0;
    led_on           = '0;
    result_valid     = 1'b0;
    foul             = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    session_start    = 1'b0;
    latch_led        = 1'b0;
    latch_press      = 1'b0;
    latch_timeout    = 1'b0;
    record           = 1'b0;
    case (state)
      S_IDLE: begin
        timer_reset = 1'b1;
        busy        = 1'b0;
        if (start_edge) begin
          session_start = 1'b1;
          state_n       = S_ARM;
        end
      end
      S_ARM: begin
        timer_load       = 1'b1;
        // A zero delay would leave WAIT immediately with no countdown; force at least 1 ms
        timer_load_value = (delay_value == '0) ? TW'(1) : delay_value;
        state_n          = S_WAIT;
      end
      S_WAIT: begin
        timer_enable = 1'b1;
        if (timer_value == '0) begin
          timer_reset = 1'b1;
          latch_led   = 1'b1;
          state_n     = S_REACT;
        end
`ifdef REACTION_FALSE_START_EN
        else if (btn_edge) begin
          state_n = S_FOUL;
        end
`endif
      end
      S_REACT: begin
        timer_enable = 1'b1;
        timer_up     = 1'b1;
        led_on       = LED_COUNT'(1) << led_idx;
        if (btn_edge) begin
          latch_press = 1'b1;
          state_n     = S_RECORD;
        end else if (timer_value == MAX_T) begin
          latch_timeout = 1'b1;
          state_n       = S_RECORD;
        end
      end
      S_RECORD: begin
        result_valid = 1'b1;
        record       = 1'b1;
        state_n      = (round_idx == LAST_ROUND) ? S_DONE : S_ARM;
      end
`ifdef REACTION_FALSE_START_EN
      S_FOUL: begin
        foul = 1'b1;
        if (btn_edge) state_n = S_ARM;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        busy = 1'b0;
        if (start_edge) begin
          session_start = 1'b1;
          state_n       = S_ARM;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Session datapath: round counter, target LED, latched result and running best
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_idx   <= '0;
      best_time   <= MAX_T;
      result_time <= '0;
      timeout     <= 1'b0;
      led_idx     <= '0;
    end else begin
      if (session_start) begin
        round_idx <= '0;
        best_time <= MAX_T;
      end
      if (latch_led) begin
        led_idx <= (int'(random_value) < LED_COUNT) ? random_value : '0;
      end
      if (latch_press) begin
        result_time <= timer_value;
        timeout     <= 1'b0;
      end else if (latch_timeout) begin
        result_time <= MAX_T;
        timeout     <= 1'b1;
      end
      if (record) begin
        if (result_time < best_time) best_time <= result_time;
        if (round_idx != LAST_ROUND) round_idx <= round_idx + RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_reaction_round_sequencer.sv
// tb/tb_reaction_round_sequencer.sv - scoreboard testbench for reaction_round_sequencer with a behavioural timer
`timescale 1ns/1ps
module tb_reaction_round_sequencer;

  localparam int MAX_MS    = 2047;
  localparam int ROUNDS    = 2;
  localparam int LED_COUNT = 18;
  localparam int TW        = $clog2(MAX_MS);
  localparam int RW        = $clog2(ROUNDS + 1);
  localparam int LW        = $clog2(LED_COUNT);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 button_pressed = 1'b0;
  logic [TW-1:0]        timer_value;
  logic [LW-1:0]        random_value = '0;
  logic [TW-1:0]        delay_value = '0;
  logic                 timer_reset, timer_load, timer_up, timer_enable;
  logic [TW-1:0]        timer_load_value;
  logic [LED_COUNT-1:0] led_on;
  logic [RW-1:0]        round_idx;
  logic                 result_valid, timeout, foul, busy, done;
  logic [TW-1:0]        result_time, best_time;

  reaction_round_sequencer #(
    .MAX_MS(MAX_MS), .ROUNDS(ROUNDS), .LED_COUNT(LED_COUNT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .button_pressed(button_pressed),
    .timer_value(timer_value), .random_value(random_value), .delay_value(delay_value),
    .timer_reset(timer_reset), .timer_load(timer_load), .timer_load_value(timer_load_value),
    .timer_up(timer_up), .timer_enable(timer_enable), .led_on(led_on),
    .round_idx(round_idx), .result_valid(result_valid), .result_time(result_time),
    .timeout(timeout), .foul(foul), .best_time(best_time), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Shared millisecond timer as seen by the sequencer: clear > load > count
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            timer_value <= '0;
    else if (timer_reset)  timer_value <= '0;
    else if (timer_load)   timer_value <= timer_load_value;
    else if (timer_enable) timer_value <= timer_up ? timer_value + 1'b1
                                        : (timer_value == '0 ? '0 : timer_value - 1'b1);
  end

  typedef struct { int t; int to; int r; } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int pd[ROUNDS], prv[ROUNDS], pk[ROUNDS];
  bit pwp[ROUNDS], pzp[ROUNDS], pnp[ROUNDS];
  int best_model, last_res, last_to;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Result monitor: every result pulse must match the oldest expected round result
  always @(negedge clk) begin
    if (rst_n && result_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got result_time %0d with empty scoreboard", result_time);
      end else begin
        mon_e = sb.pop_front();
        check("result_time", 32'(result_time), mon_e.t);
        check("result_timeout", 32'(timeout), mon_e.to);
        check("result_round", 32'(round_idx), mon_e.r);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic press();
    button_pressed = 1'b1;
    @(negedge clk);
    button_pressed = 1'b0;
  endtask

  task automatic do_round(input int r);
    bit got, zdone;
    int exp_led, kk;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (timer_load) begin got = 1; break; end
      @(negedge clk);
    end
    check("arm_seen", 32'(got), 1);
    check("load_value", 32'(timer_load_value), (pd[r] == 0) ? 1 : pd[r]);
    check("arm_round_idx", 32'(round_idx), r);
    check("arm_best_time", 32'(best_time), best_model);
    if (pwp[r] && pd[r] >= 2) begin
      @(negedge clk);
      press();
`ifdef REACTION_FALSE_START_EN
      check("foul_set", 32'(foul), 1);
      check("foul_timer_enable", 32'(timer_enable), 0);
      check("foul_led", 32'(led_on), 0);
      check("foul_round_idx", 32'(round_idx), r);
      press();
      check("foul_rearm", 32'(timer_load), 1);
      check("rearm_round_idx", 32'(round_idx), r);
`else
      check("wait_press_ignored", 32'(foul), 0);
      check("wait_still_counting", 32'(timer_enable), 1);
      check("wait_led_dark", 32'(led_on), 0);
`endif
    end
    got = 0;
    zdone = 0;
    for (int i = 0; i < 40; i++) begin
      if (led_on != '0) begin got = 1; break; end
      if (pzp[r] && !zdone && timer_enable && !timer_up && timer_value == '0) begin
        button_pressed = 1'b1;
        zdone = 1;
      end
      @(negedge clk);
      button_pressed = 1'b0;
    end
    check("led_lit", 32'(got), 1);
    exp_led = (prv[r] < LED_COUNT) ? prv[r] : 0;
    check("led_onehot", 32'(led_on), 32'(1) << exp_led);
    check("react_no_foul", 32'(foul), 0);
    if (pzp[r]) check("zero_press_issued", 32'(zdone), 1);
    if (r + 1 < ROUNDS) begin
      delay_value  = TW'(pd[r+1]);
      random_value = LW'(prv[r+1]);
    end
    if (pnp[r]) begin
      sb.push_back('{MAX_MS, 1, r});
      last_res = MAX_MS;
      last_to = 1;
      got = 0;
      for (int i = 0; i < MAX_MS + 20; i++) begin
        @(negedge clk);
        if (led_on == '0) begin got = 1; break; end
      end
      check("timeout_reached", 32'(got), 1);
    end else begin
      kk = (pzp[r] && pk[r] < 1) ? 1 : pk[r];
      repeat (kk) @(negedge clk);
      sb.push_back('{kk, 0, r});
      if (kk < best_model) best_model = kk;
      last_res = kk;
      last_to = 0;
      press();
    end
  endtask

  task automatic start_session();
    delay_value  = TW'(pd[0]);
    random_value = LW'(prv[0]);
    best_model   = MAX_MS;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("session_busy", 32'(busy), 1);
  endtask

  task automatic run_session();
    start_session();
    for (int r = 0; r < ROUNDS; r++) do_round(r);
    @(negedge clk);
    check("done_set", 32'(done), 1);
    check("done_not_busy", 32'(busy), 0);
    check("done_best_time", 32'(best_time), best_model);
    check("done_result_held", 32'(result_time), last_res);
    check("done_timeout", 32'(timeout), last_to);
    check("done_round_idx", 32'(round_idx), ROUNDS - 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_timer_reset"}, 32'(timer_reset), 1);
    check({tag, "_timer_enable"}, 32'(timer_enable), 0);
    check({tag, "_timer_load"}, 32'(timer_load), 0);
    check({tag, "_led_on"}, 32'(led_on), 0);
    check({tag, "_round_idx"}, 32'(round_idx), 0);
    check({tag, "_best_time"}, 32'(best_time), MAX_MS);
    check({tag, "_result_time"}, 32'(result_time), 0);
    check({tag, "_timeout"}, 32'(timeout), 0);
    check({tag, "_result_valid"}, 32'(result_valid), 0);
    check({tag, "_foul"}, 32'(foul), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Two rounds, 5 ms delay, press 7 cycles after the LED; out-of-range LED index
    for (int r = 0; r < ROUNDS; r++) begin
      pd[r] = 5; pk[r] = 7; pwp[r] = 0; pzp[r] = 0; pnp[r] = 0;
    end
    prv[0] = 20; prv[1] = 3;
    run_session();

    // Timeout first (best stays MAX), then zero-delay with a press as the countdown hits 0
    pd[0] = 6; prv[0] = 17; pk[0] = 0; pwp[0] = 1; pzp[0] = 0; pnp[0] = 1;
    pd[1] = 0; prv[1] = 20; pk[1] = 4; pwp[1] = 0; pzp[1] = 1; pnp[1] = 0;
    run_session();

    for (int s = 0; s < 8; s++) begin
      for (int r = 0; r < ROUNDS; r++) begin
        pd[r]  = $urandom_range(0, 6);
        prv[r] = $urandom_range(0, 31);
        pk[r]  = $urandom_range(1, 12);
        pwp[r] = ($urandom_range(0, 2) == 0);
        pzp[r] = ($urandom_range(0, 3) == 0);
        pnp[r] = 0;
      end
      run_session();
    end

    // Asynchronous reset while the second round's LED is lit
    pd[0] = 3; prv[0] = 9;  pk[0] = 2; pwp[0] = 0; pzp[0] = 0; pnp[0] = 0;
    pd[1] = 4; prv[1] = 11; pk[1] = 5; pwp[1] = 0; pzp[1] = 0; pnp[1] = 0;
    start_session();
    do_round(0);
    for (int i = 0; i < 40; i++) begin
      if (led_on != '0) break;
      @(negedge clk);
    end
    check("pre_reset_round1", 32'(round_idx), 1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    check("midreset_no_pending", 32'(sb.size()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < ROUNDS; r++) begin
      pd[r]  = $urandom_range(0, 6);
      prv[r] = $urandom_range(0, 31);
      pk[r]  = $urandom_range(1, 12);
      pwp[r] = 1;
      pzp[r] = 0;
      pnp[r] = 0;
    end
    run_session();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
